// File: rtl/softmax_writeback_pkg.sv
// Shared definitions for the softmax writeback block.
// Holds the default lane/address geometry, the writeback state encoding,
// and small helpers used by the top and by the FIFO.
package softmax_writeback_pkg;

  localparam int unsigned SM_DATAWIDTH  = 16;
  localparam int unsigned SM_NUM        = 4;
  localparam int unsigned SM_ADDRSIZE   = 8;
  localparam int unsigned SM_FIFO_DEPTH = 8;

  // Writeback controller states.
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RUN  = 2'd1,
    WB_DONE = 2'd2
  } wb_state_t;

  // True when the value is a nonzero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/softmax_wb_fifo.sv
// Synchronous FIFO buffering result beats ahead of the memory write port.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push, din   - write request and data (taken when not full, or full with pop)
//   pop         - read request (ignored when empty)
//   dout        - head entry, combinational read of registered storage
//   full, empty - occupancy flags
//   count       - number of stored entries
module softmax_wb_fifo
  import softmax_writeback_pkg::*;
#(
  parameter int unsigned WIDTH = SM_DATAWIDTH * SM_NUM,
  parameter int unsigned DEPTH = SM_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy and head read.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (count == DEPTH_CNT);
    empty = (wr_ptr == rd_ptr);
    dout  = mem[rd_ptr[AW-1:0]];
  end

  // A push into a full FIFO is still taken when a pop frees the head slot.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Depth must be a power of two of at least two for the pointer scheme.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (is_pow2(DEPTH) && (DEPTH >= 2));
    end
  end

endmodule

// File: rtl/softmax_writeback.sv
// Softmax result writeback: buffers result beats presented with the softmax
// done strobe and drains them to an on-chip memory write port at consecutive
// addresses from a latched base, pulsing wb_done when the job completes.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   init            - start a job (accepted in IDLE only)
//   out_start_addr  - first write address of the job
//   num_beats       - number of beats the job writes
//   in_valid/in_data- result beat, lane0 in the LSBs
//   wr_en/wr_ready  - write handshake; a write happens when both are high
//   wr_addr/wr_data - write address and FIFO head data
//   busy            - job running
//   wb_done         - one-cycle completion pulse
//   overflow        - sticky, a beat was dropped because the FIFO was full
module softmax_writeback
  import softmax_writeback_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = SM_DATAWIDTH,
  parameter int unsigned NUM        = SM_NUM,
  parameter int unsigned ADDRSIZE   = SM_ADDRSIZE,
  parameter int unsigned FIFO_DEPTH = SM_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [ADDRSIZE-1:0]       out_start_addr,
  input  logic [ADDRSIZE-1:0]       num_beats,
  input  logic                      in_valid,
  input  logic [DATAWIDTH*NUM-1:0]  in_data,
  output logic                      wr_en,
  input  logic                      wr_ready,
  output logic [ADDRSIZE-1:0]       wr_addr,
  output logic [DATAWIDTH*NUM-1:0]  wr_data,
  output logic                      busy,
  output logic                      wb_done,
  output logic                      overflow
);

  localparam int unsigned BEATW = DATAWIDTH * NUM;
  // One spare bit so a target of 2^ADDRSIZE-1 completes without wrapping.
  localparam int unsigned CNTW  = ADDRSIZE + 1;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  wb_state_t        state;
  wb_state_t        state_next;

  logic [CNTW-1:0]  target;
  logic [CNTW-1:0]  accepted;
  logic [CNTW-1:0]  written;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [BEATW-1:0] fifo_head;

  logic             start_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;
  logic             last_pop_c;

  softmax_wb_fifo #(
    .WIDTH (BEATW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (in_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Handshake and counter qualifiers.
  always_comb begin
    start_c    = (state == WB_IDLE) && init;
    // Beats past the programmed target are ignored, not counted as overflow.
    push_c     = (state == WB_RUN) && in_valid && (accepted < target);
    pop_c      = wr_en && wr_ready;
    drop_c     = push_c && fifo_full && !pop_c;
    last_pop_c = pop_c && ((written + CNTW'(1)) == target);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A job with dropped beats never reaches its target
  // and stays in RUN until reset; overflow flags that case.
  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE: begin
        if (init) begin
          state_next = (num_beats == '0) ? WB_DONE : WB_RUN;
        end
      end
      WB_RUN: begin
        if (last_pop_c) begin
          state_next = WB_DONE;
        end
      end
      WB_DONE: begin
        state_next = WB_IDLE;
      end
      default: begin
        state_next = WB_IDLE;
      end
    endcase
  end

  // Output decode; all terms come from registers.
  always_comb begin
    wr_en   = 1'b0;
    busy    = 1'b0;
    wb_done = 1'b0;
    wr_data = fifo_head;
    case (state)
      WB_RUN: begin
        busy  = 1'b1;
        wr_en = !fifo_empty;
      end
      WB_DONE: begin
        wb_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Job bookkeeping: address, beat counters and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      target   <= '0;
      accepted <= '0;
      written  <= '0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else if (start_c) begin
      target   <= CNTW'(num_beats);
      accepted <= '0;
      written  <= '0;
      wr_addr  <= out_start_addr;
      overflow <= 1'b0;
    end else begin
      // A dropped beat still counts as accepted so the producer side ends.
      if (push_c) begin
        accepted <= accepted + CNTW'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (pop_c) begin
        written <= written + CNTW'(1);
        wr_addr <= wr_addr + ADDRSIZE'(1);
      end
    end
  end

  // FIFO occupancy can never exceed its depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (fifo_count <= FCW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_softmax_writeback.sv
// Bench for softmax_writeback: table-driven jobs, hand-written corner
// sequences and randomized jobs, all checked cycle by cycle against a
// queue-based reference model of the writeback behaviour.
module tb_softmax_writeback;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [7:0]  out_start_addr;
  logic [7:0]  num_beats;
  logic        in_valid;
  logic [63:0] in_data;
  logic        wr_en;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        wb_done;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int obs_writes;
  int obs_dones;

  // Reference model state.
  bit          m_running;
  bit          m_done;
  bit          m_ovf;
  logic [7:0]  m_addr;
  int          m_tgt;
  int          m_acc;
  int          m_wr;
  logic [63:0] m_q[$];

  softmax_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .out_start_addr (out_start_addr),
    .num_beats      (num_beats),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .wr_en          (wr_en),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .wb_done        (wb_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    int         nbeats;
    int         feed;
    int         stall;
    int         exp_wr;
    bit         exp_ovf;
    int         exp_done;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat(input int k);
    return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
  endfunction

  function automatic void model_clear();
    m_running = 0;
    m_done    = 0;
    m_ovf     = 0;
    m_addr    = '0;
    m_tgt     = 0;
    m_acc     = 0;
    m_wr      = 0;
    m_q.delete();
  endfunction

  // Called at a negedge: check outputs, drive inputs, advance model and DUT one edge.
  task automatic step(input bit v, input logic [63:0] d, input bit rdy,
                      input bit ini, input logic [7:0] a, input logic [7:0] n);
    bit exp_en;
    bit pop;
    bit was_full;
    bit next_done;
    exp_en = m_running && (m_q.size() > 0);
    chk("wr_en", 64'(wr_en), 64'(exp_en));
    chk("busy", 64'(busy), 64'(m_running));
    chk("wb_done", 64'(wb_done), 64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (exp_en) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", wr_data, m_q[0]);
    end
    if (wr_en && rdy) obs_writes++;
    if (wb_done) obs_dones++;

    in_valid       = v;
    in_data        = d;
    wr_ready       = rdy;
    init           = ini;
    out_start_addr = a;
    num_beats      = n;

    next_done = 0;
    if (ini && !m_running && !m_done) begin
      m_tgt  = int'(n);
      m_acc  = 0;
      m_wr   = 0;
      m_addr = a;
      m_ovf  = 0;
      if (n == 0) next_done = 1;
      else m_running = 1;
    end else if (m_running) begin
      pop      = (m_q.size() > 0) && rdy;
      was_full = (m_q.size() == DEPTH);
      if (pop) begin
        void'(m_q.pop_front());
        m_wr++;
        m_addr++;
        if (m_wr == m_tgt) begin
          m_running = 0;
          next_done = 1;
        end
      end
      if (v && (m_acc < m_tgt)) begin
        m_acc++;
        if (was_full && !pop) m_ovf = 1;
        else m_q.push_back(d);
      end
    end
    m_done = next_done;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_zero);
    reset    = 1'b1;
    init     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    wr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    if (check_zero) begin
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_wr_addr", 64'(wr_addr), 64'(0));
      chk("rst_wr_data", wr_data, 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_wb_done", 64'(wb_done), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
    end
  endtask

  initial begin
    reset          = 1'b1;
    init           = 1'b0;
    out_start_addr = '0;
    num_beats      = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    wr_ready       = 1'b0;
    model_clear();
    @(negedge clk);

    //            addr   n   feed stall wr ovf done busy
    vecs[0] = '{8'h10,  3,  3,  0,  3, 1'b0, 1, 1'b0};  // basic job
    vecs[1] = '{8'h10,  3,  3,  5,  3, 1'b0, 1, 1'b0};  // backpressure
    vecs[2] = '{8'h40, 10, 10, 12,  8, 1'b1, 0, 1'b1};  // overflow, job stuck
    vecs[3] = '{8'hFE,  4,  4,  0,  4, 1'b0, 1, 1'b0};  // address wrap
    vecs[4] = '{8'h00,  0,  2,  0,  0, 1'b0, 1, 1'b0};  // zero-beat job
    vecs[5] = '{8'h05,  2,  5,  0,  2, 1'b0, 1, 1'b0};  // excess beats ignored
    vecs[6] = '{8'h30,  9,  9,  8,  9, 1'b0, 1, 1'b0};  // push into full with pop

    foreach (vecs[i]) begin
      do_reset(1'b1);
      obs_writes = 0;
      obs_dones  = 0;
      step(0, '0, 1, 1, vecs[i].addr, 8'(vecs[i].nbeats));
      for (int k = 0; k < 30; k++) begin
        step(k < vecs[i].feed, beat(k), k >= vecs[i].stall, 0, '0, '0);
      end
      chk($sformatf("vec%0d_writes", i), 64'(obs_writes), 64'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_dones", i), 64'(obs_dones), 64'(vecs[i].exp_done));
      chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    // in_valid while idle never reaches the write port.
    do_reset(1'b1);
    obs_writes = 0;
    for (int k = 0; k < 3; k++) step(1, beat(k), 1, 0, '0, '0);
    chk("idle_in_valid_writes", 64'(obs_writes), 64'(0));

    // Reset after two of four beats written, then a clean one-beat job.
    do_reset(1'b1);
    step(0, '0, 1, 1, 8'h50, 8'd4);
    for (int k = 0; k < 3; k++) step(1, beat(k + 20), 1, 0, '0, '0);
    chk("mid_busy_before_reset", 64'(busy), 64'(1));
    do_reset(1'b1);
    obs_writes = 0;
    obs_dones  = 0;
    step(0, '0, 1, 1, 8'h20, 8'd1);
    step(1, 64'hDEAD_BEEF_0123_4567, 1, 0, '0, '0);
    chk("post_reset_wr_addr", 64'(wr_addr), 64'h20);
    chk("post_reset_wr_data", wr_data, 64'hDEAD_BEEF_0123_4567);
    for (int k = 0; k < 4; k++) step(0, '0, 1, 0, '0, '0);
    chk("post_reset_writes", 64'(obs_writes), 64'(1));
    chk("post_reset_dones", 64'(obs_dones), 64'(1));

    // Randomized jobs, including init attempts while busy or done.
    for (int j = 0; j < 12; j++) begin
      int ready_pct;
      ready_pct = (j % 3 == 0) ? 15 : 70;
      do_reset(1'b0);
      step(0, '0, 1, 1, 8'($urandom), 8'($urandom_range(0, 14)));
      for (int k = 0; k < 80; k++) begin
        bit ini;
        ini = ($urandom_range(0, 19) == 0);
        step($urandom_range(0, 3) != 0, {$urandom, $urandom},
             $urandom_range(0, 99) < ready_pct, ini,
             8'($urandom), 8'($urandom_range(0, 12)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_writeback.md
Name: softmax_writeback

Overview:
- Downstream consumer of the softmax datapath.
- Captures each packed result beat (NUM lanes of DATAWIDTH) presented with the softmax done strobe, and buffers beats in a small FIFO.
- Drains the FIFO to an on-chip memory write port under a valid/ready handshake, writing consecutive addresses from a latched base.
- Pulses completion once the programmed number of beats has been written.

Parameters:
- DATAWIDTH, 16, bits per lane
- NUM, 4, lanes per beat
- ADDRSIZE, 8, memory address width
- FIFO_DEPTH, 8, beats of buffering (power of two, >=2)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- init  input  1  latch out_start_addr/num_beats, begin job
- out_start_addr  input  ADDRSIZE  first write address
- num_beats  input  ADDRSIZE  beats to write this job
- in_valid  input  1  result beat valid (softmax done)
- in_data  input  DATAWIDTH*NUM  {outp3,outp2,outp1,outp0}; lane0 in LSBs
- wr_en  output  1  write request valid
- wr_ready  input  1  memory accepts write this cycle
- wr_addr  output  ADDRSIZE  write address
- wr_data  output  DATAWIDTH*NUM  write data (FIFO head)
- busy  output  1  job in progress
- wb_done  output  1  one-cycle completion pulse
- overflow  output  1  sticky: beat dropped

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, wb_done=0, overflow=0.
  - FIFO empty, all counters 0, state IDLE.
  - Reset mid-job abandons the job; buffered beats are discarded.
- States:
  - IDLE:
    - init -> RUN, latching base=out_start_addr and target=num_beats; wr_addr<=out_start_addr; overflow cleared.
    - If num_beats==0 -> DONE instead.
    - in_valid in IDLE is ignored; it does not push into the FIFO.
  - RUN:
    - busy=1.
    - Push when in_valid and accepted_count<target; beats beyond target are ignored (not overflow).
    - Write completion: written_count==target after a pop -> DONE.
    - init while in RUN is ignored.
  - DONE: wb_done=1 for exactly one cycle, busy=0; next state IDLE. init in DONE is ignored.
- Write side:
  - wr_en = (state==RUN) && FIFO non-empty.
  - wr_data = FIFO head, registered storage with combinational read of head.
  - Pop on wr_en && wr_ready. On a pop, wr_addr increments and written_count increments.
  - wr_addr wraps modulo 2^ADDRSIZE.
  - wr_en/wr_data/wr_addr are held stable while wr_ready=0.
- Latency: a beat pushed at edge N appears with wr_en=1 in the cycle after edge N (FIFO previously empty). With wr_ready=1 it is written at edge N+1.
- Full/empty:
  - Push while full with a simultaneous pop is accepted.
  - Push while full with no pop drops the beat and sets overflow (sticky until next accepted init or reset); accepted_count still increments so the job can terminate.
  - Pop while empty cannot occur (wr_en=0).
- Counters are ADDRSIZE+1 bits so that a target of 2^ADDRSIZE-1 completes without wrap.
- Overflow consequence: if beats were dropped, written_count never reaches target. The job then stays in RUN until reset. This is documented behaviour; overflow flags it.
- Throughput: one beat per cycle sustained when wr_ready=1.

Decomposition:
- Shared defines file: DATAWIDTH, NUM, ADDRSIZE, and the writeback state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, softmax_wb_fifo:
  - Synchronous FIFO of width DATAWIDTH*NUM, depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pointer wrap via an extra MSB.
- The top module holds the FSM, the address counter and the beat counters.

Test Plan:
- Basic job: init with out_start_addr=0x10, num_beats=3, wr_ready=1; three in_valid beats 0x0004_0003_0002_0001, 0x...05..08, 0x...09..0C.
  - Writes land at 0x10/0x11/0x12 in order, each one cycle after its push.
  - wb_done pulses once one cycle after the third write; busy then 0.
- Backpressure: same job with wr_ready=0 for 5 cycles.
  - wr_en=1 with wr_addr=0x10 and wr_data held constant throughout.
  - After release, all three beats are written, no overflow.
- Overflow: FIFO_DEPTH=8, wr_ready=0, num_beats=10, 10 consecutive beats.
  - First 8 buffered; 9th and 10th dropped; overflow=1.
  - With wr_ready=1, 8 writes complete; no wb_done; busy stays 1.
- Full with simultaneous pop: FIFO full, in_valid and wr_ready both high in the same cycle.
  - Push accepted, count stays 8, overflow=0.
- Edge cases: num_beats=0 -> wb_done pulse in the cycle after init, no wr_en. in_valid in IDLE -> no write.
- Reset mid-job: reset after 2 of 4 beats written -> all outputs 0 next cycle. A new init (addr 0x20, 1 beat) then runs cleanly.
